// File: rtl/jtag_bus_master.sv
// jtag_bus_master: bridges the level-held debug memory request to one
// request/grant/response transaction on the system bus. It returns read
// data, an acknowledge and a sticky timeout error to the debug side.
module jtag_bus_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // debug-side access port
  input  logic              op_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              ack_o,
  output logic              busy_o,
  output logic              err_o,
  // system bus master port
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Last count value before the access is declared dead.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        op_req_q;
  logic [15:0] cnt;
  logic        start;
  logic        timeout_hit;

  // A new access starts only on a rising edge of the level request seen in IDLE.
  assign start       = op_req_i & ~op_req_q & (state == IDLE);
  assign timeout_hit = (cnt == CNT_LAST);

  // Transaction FSM with registered handshake, bus and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_req_q    <= 1'b0;
      cnt         <= 16'd0;
      mem_rdata_o <= '0;
      ack_o       <= 1'b0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
    end else begin
      op_req_q <= op_req_i;
      case (state)
        IDLE: begin
          if (start) begin
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= mem_addr_i;
            bus_wdata_o <= mem_wdata_i;
            err_o       <= 1'b0;
            cnt         <= 16'd0;
            bus_req_o   <= 1'b1;
            busy_o      <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt + 16'd1;
          // Completion has priority over a timeout landing in the same cycle;
          // a bare grant on the last cycle does not complete, so it times out.
          if (bus_gnt_i && bus_rvalid_i) begin
            if (!bus_we_o) mem_rdata_o <= bus_rdata_i;
            bus_req_o <= 1'b0;
            ack_o     <= 1'b1;
            state     <= DONE;
          end else if (timeout_hit) begin
            err_o     <= 1'b1;
            bus_req_o <= 1'b0;
            ack_o     <= 1'b1;
            state     <= DONE;
          end else if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            state     <= RSP;
          end
        end
        RSP: begin
          cnt <= cnt + 16'd1;
          if (bus_rvalid_i) begin
            if (!bus_we_o) mem_rdata_o <= bus_rdata_i;
            ack_o <= 1'b1;
            state <= DONE;
          end else if (timeout_hit) begin
            err_o <= 1'b1;
            ack_o <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // Hold the acknowledge until the host releases its request.
          if (!op_req_i) begin
            ack_o  <= 1'b0;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_bus_master.sv
// tb_jtag_bus_master: randomized access scenarios checked cycle by cycle
// against a transaction-level timing model of the bridge.
module tb_jtag_bus_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          op_req_i;
  logic          mem_we_i;
  logic [AW-1:0] mem_addr_i;
  logic [DW-1:0] mem_wdata_i;
  logic [DW-1:0] mem_rdata_o;
  logic          ack_o;
  logic          busy_o;
  logic          err_o;
  logic          bus_req_o;
  logic          bus_we_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic          bus_gnt_i;
  logic          bus_rvalid_i;
  logic [DW-1:0] bus_rdata_i;

  int checks = 0;
  int errors = 0;

  // Architectural state the model carries between accesses.
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_we;
  logic          m_err;

  jtag_bus_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_req_i     (op_req_i),
    .mem_we_i     (mem_we_i),
    .mem_addr_i   (mem_addr_i),
    .mem_wdata_i  (mem_wdata_i),
    .mem_rdata_o  (mem_rdata_o),
    .ack_o        (ack_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  always #5 clk = ~clk;

  // Watchdog so a stuck run still terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // One access. Called at a falling edge (cycle 0). g = cycle the grant is
  // driven (beyond TO: never), r = cycles from grant to rvalid (0: same
  // cycle), drop_c = first cycle op_req_i is driven low (>= 1).
  task automatic run_access(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input int g, input int r,
                            input int drop_c, input logic [DW-1:0] rsp_data);
    int            comp, done_c, exit_c, req_last;
    bit            to;
    logic [DW-1:0] cap;
    logic          e_busy, e_ack, e_req, e_err, e_we;
    logic [DW-1:0] e_rdata, e_wdata;
    logic [AW-1:0] e_addr;
    comp     = (g <= TO) ? g + r : 1 << 20;
    to       = (comp > TO);
    done_c   = (to ? TO : comp) + 1;
    exit_c   = ((done_c > drop_c) ? done_c : drop_c) + 1;
    req_last = (g <= TO) ? g : TO;
    cap      = m_rdata;
    for (int c = 0; c <= exit_c; c++) begin
      if (c > 0) @(negedge clk);
      e_busy  = (c >= 1) && (c < exit_c);
      e_ack   = (c >= done_c) && (c < exit_c);
      e_req   = (c >= 1) && (c <= req_last);
      e_err   = (c >= 1) ? (to && (c >= done_c)) : m_err;
      e_rdata = ((c >= done_c) && !we && !to) ? cap : m_rdata;
      e_addr  = (c >= 1) ? addr : m_addr;
      e_wdata = (c >= 1) ? wdata : m_wdata;
      e_we    = (c >= 1) ? we : m_we;
      checks += 8;
      if (busy_o !== e_busy) begin
        errors++; $display("FAIL busy c=%0d: got %b want %b", c, busy_o, e_busy);
      end
      if (ack_o !== e_ack) begin
        errors++; $display("FAIL ack c=%0d: got %b want %b", c, ack_o, e_ack);
      end
      if (bus_req_o !== e_req) begin
        errors++; $display("FAIL bus_req c=%0d: got %b want %b", c, bus_req_o, e_req);
      end
      if (err_o !== e_err) begin
        errors++; $display("FAIL err c=%0d: got %b want %b", c, err_o, e_err);
      end
      if (mem_rdata_o !== e_rdata) begin
        errors++; $display("FAIL mem_rdata c=%0d: got %h want %h", c, mem_rdata_o, e_rdata);
      end
      if (bus_addr_o !== e_addr) begin
        errors++; $display("FAIL bus_addr c=%0d: got %h want %h", c, bus_addr_o, e_addr);
      end
      if (bus_wdata_o !== e_wdata) begin
        errors++; $display("FAIL bus_wdata c=%0d: got %h want %h", c, bus_wdata_o, e_wdata);
      end
      if (bus_we_o !== e_we) begin
        errors++; $display("FAIL bus_we c=%0d: got %b want %b", c, bus_we_o, e_we);
      end
      // Drive inputs for the edge that ends cycle c.
      if (c == 0) begin
        op_req_i    = 1'b1;
        mem_we_i    = we;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
      end else begin
        op_req_i    = (c < drop_c);
        mem_we_i    = 1'($urandom);
        mem_addr_i  = $urandom;
        mem_wdata_i = $urandom;
      end
      bus_gnt_i    = (g <= TO) && (c == g);
      bus_rvalid_i = (g <= TO) && (c == g + r);
      bus_rdata_i  = (c == g + r) ? rsp_data : $urandom;
      if (c == comp && !to) cap = rsp_data;
    end
    m_err   = to;
    m_addr  = addr;
    m_wdata = wdata;
    m_we    = we;
    if (!we && !to) m_rdata = cap;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({mem_rdata_o, ack_o, busy_o, err_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o} !== '0) begin
      errors++;
      $display("FAIL %s: outputs rdata=%h ack=%b busy=%b err=%b req=%b we=%b addr=%h wdata=%h want all 0",
               tag, mem_rdata_o, ack_o, busy_o, err_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op_req_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
    #1;
    check_all_zero("reset_values");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_rdata = '0; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_err = 1'b0;
    @(negedge clk);
    check_all_zero("after_release");
  endtask

  task automatic test_read();
    run_access(1'b0, 32'h2000_0010, $urandom, 3, 1, 6, 32'hCAFE_F00D);
  endtask

  task automatic test_write();
    @(negedge clk);
    run_access(1'b1, 32'h1000_0004, 32'h1234_5678, 2, 0, 4, $urandom);
  endtask

  task automatic test_timeout();
    @(negedge clk);
    run_access(1'b0, $urandom, $urandom, 100, 0, 3, $urandom);   // never granted
    run_access(1'b0, $urandom, $urandom, 2, 1, 2, $urandom);     // err cleared at start
    run_access(1'b0, $urandom, $urandom, 8, 1, 12, $urandom);    // bare grant on last cycle
    run_access(1'b1, $urandom, $urandom, 5, 5, 1, $urandom);     // times out in RSP
    run_access(1'b0, $urandom, $urandom, 8, 0, 1, $urandom);     // completion wins tie
    run_access(1'b0, $urandom, $urandom, 7, 1, 1, $urandom);     // completion wins tie in RSP
  endtask

  task automatic test_early_drop();
    @(negedge clk);
    run_access(1'b0, $urandom, $urandom, 1, 3, 2, $urandom);
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, $urandom, $urandom, 1, 1, 1, $urandom);
    run_access(1'b1, $urandom, $urandom, 1, 0, 1, $urandom);
    run_access(1'b0, $urandom, $urandom, 2, 0, 3, $urandom);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      run_access(1'($urandom), $urandom, $urandom, $urandom_range(1, 10),
                 $urandom_range(0, 4), $urandom_range(1, 12), $urandom);
    end
  endtask

  task automatic test_reset_in_rsp();
    @(negedge clk);
    op_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0BAD; mem_wdata_i = $urandom;
    @(negedge clk);
    bus_gnt_i = 1'b1;
    @(negedge clk);
    bus_gnt_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || bus_req_o !== 1'b0) begin
      errors++; $display("FAIL rsp_entry: busy=%b req=%b want busy=1 req=0", busy_o, bus_req_o);
    end
    #2 rst_n = 1'b0;
    op_req_i = 1'b0;
    #1;
    check_all_zero("reset_in_rsp");
    @(negedge clk);
    rst_n = 1'b1;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_rvalid_i = 1'b0;
    check_all_zero("late_rvalid_ignored");
    m_rdata = '0; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_err = 1'b0;
    run_access(1'b0, $urandom, $urandom, 2, 2, 2, $urandom);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_early_drop();
    test_back_to_back();
    test_random();
    test_reset_in_rsp();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
